// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Brings the board PLL out of reset, qualifies its lock, and
//               releases per-domain resets one stage at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 1048576,
    parameter int LOCK_STABLE    = 1024,
    parameter int STAGE_DELAY    = 256,
    parameter int NUM_STAGES     = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    output logic                  pll_rst,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  ready,
    output logic [7:0]            retry_count
);

    localparam int c_max_ab = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int c_max_cd = (LOCK_STABLE > STAGE_DELAY) ? LOCK_STABLE : STAGE_DELAY;
    localparam int c_max    = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
    localparam int c_cnt_w  = $clog2(c_max) + 1;

    localparam logic [c_cnt_w-1:0] c_rst_last     = c_cnt_w'(PLL_RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(LOCK_TIMEOUT - 1);
    // The WAITLOCK edge that first sees lock is already one stable cycle.
    localparam logic [c_cnt_w-1:0] c_stable_last  = c_cnt_w'((LOCK_STABLE >= 2) ? (LOCK_STABLE - 2) : 0);
    localparam logic [c_cnt_w-1:0] c_delay_last   = c_cnt_w'(STAGE_DELAY - 1);

    typedef enum logic [2:0] {
        ST_PLLRST   = 3'd0,
        ST_WAITLOCK = 3'd1,
        ST_STABLE   = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_RUN      = 3'd4
    } state_t;

    logic                  r_lock_meta;
    logic                  r_lock_sync;
    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_cnt_w-1:0]    w_cnt_nxt;
    logic                  r_pll_rst;
    logic                  w_pll_rst_nxt;
    logic [NUM_STAGES-1:0] r_stage_rst_n;
    logic [NUM_STAGES-1:0] w_stage_nxt;
    logic [NUM_STAGES-1:0] w_stage_step;
    logic                  r_ready;
    logic                  w_ready_nxt;
    logic [7:0]            r_retry;
    logic                  w_retry_bump;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_sync <= r_lock_meta;
        end
    end

    // Stages are released strictly low-to-high by shifting in ones.
    assign w_stage_step = (r_stage_rst_n << 1) | NUM_STAGES'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + 1'b1;
        w_pll_rst_nxt = r_pll_rst;
        w_stage_nxt   = r_stage_rst_n;
        w_ready_nxt   = r_ready;
        w_retry_bump  = 1'b0;

        case (r_state)
            ST_PLLRST: begin
                w_pll_rst_nxt = 1'b1;
                w_stage_nxt   = '0;
                w_ready_nxt   = 1'b0;
                if (r_cnt == c_rst_last) begin
                    w_state_nxt   = ST_WAITLOCK;
                    w_cnt_nxt     = '0;
                    w_pll_rst_nxt = 1'b0;
                end
            end

            ST_WAITLOCK: begin
                if (r_lock_sync) begin
                    w_cnt_nxt = '0;
                    if (LOCK_STABLE == 1) begin
                        w_stage_nxt = w_stage_step;
                        if (&w_stage_step) begin
                            w_ready_nxt = 1'b1;
                            w_state_nxt = ST_RUN;
                        end else begin
                            w_state_nxt = ST_RELEASE;
                        end
                    end else begin
                        w_state_nxt = ST_STABLE;
                    end
                end else if (r_cnt == c_timeout_last) begin
                    w_state_nxt   = ST_PLLRST;
                    w_cnt_nxt     = '0;
                    w_pll_rst_nxt = 1'b1;
                    w_retry_bump  = 1'b1;
                end
            end

            ST_STABLE: begin
                if (!r_lock_sync) begin
                    w_state_nxt   = ST_PLLRST;
                    w_cnt_nxt     = '0;
                    w_pll_rst_nxt = 1'b1;
                    w_stage_nxt   = '0;
                    w_ready_nxt   = 1'b0;
                    w_retry_bump  = 1'b1;
                end else if (r_cnt == c_stable_last) begin
                    w_cnt_nxt   = '0;
                    w_stage_nxt = w_stage_step;
                    if (&w_stage_step) begin
                        w_ready_nxt = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_RELEASE;
                    end
                end
            end

            ST_RELEASE: begin
                if (!r_lock_sync) begin
                    w_state_nxt   = ST_PLLRST;
                    w_cnt_nxt     = '0;
                    w_pll_rst_nxt = 1'b1;
                    w_stage_nxt   = '0;
                    w_ready_nxt   = 1'b0;
                    w_retry_bump  = 1'b1;
                end else if (r_cnt == c_delay_last) begin
                    w_cnt_nxt   = '0;
                    w_stage_nxt = w_stage_step;
                    if (&w_stage_step) begin
                        w_ready_nxt = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                w_cnt_nxt = r_cnt;
                if (!r_lock_sync) begin
                    w_state_nxt   = ST_PLLRST;
                    w_cnt_nxt     = '0;
                    w_pll_rst_nxt = 1'b1;
                    w_stage_nxt   = '0;
                    w_ready_nxt   = 1'b0;
                    w_retry_bump  = 1'b1;
                end
            end

            default: begin
                w_state_nxt   = ST_PLLRST;
                w_cnt_nxt     = '0;
                w_pll_rst_nxt = 1'b1;
                w_stage_nxt   = '0;
                w_ready_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_PLLRST;
            r_cnt         <= '0;
            r_pll_rst     <= 1'b1;
            r_stage_rst_n <= '0;
            r_ready       <= 1'b0;
            r_retry       <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_pll_rst     <= w_pll_rst_nxt;
            r_stage_rst_n <= w_stage_nxt;
            r_ready       <= w_ready_nxt;
            if (w_retry_bump && (r_retry != 8'hFF)) begin
                r_retry <= r_retry + 8'd1;
            end
        end
    end

    assign pll_rst     = r_pll_rst;
    assign stage_rst_n = r_stage_rst_n;
    assign ready       = r_ready;
    assign retry_count = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_sequencer
// Description : Self-checking bench: vector table, corner sequences, and
//               random lock stimulus against a timestamp-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

    localparam int PRC = 4;
    localparam int TO  = 50;
    localparam int LS  = 8;
    localparam int SD  = 3;
    localparam int NS  = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pll_locked = 1'b0;
    logic          pll_rst;
    logic [NS-1:0] stage_rst_n;
    logic          ready;
    logic [7:0]    retry_count;

    int n_cmp = 0;
    int n_bad = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (PRC),
        .LOCK_TIMEOUT   (TO),
        .LOCK_STABLE    (LS),
        .STAGE_DELAY    (SD),
        .NUM_STAGES     (NS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .stage_rst_n (stage_rst_n),
        .ready       (ready),
        .retry_count (retry_count)
    );

    always #5 clk = ~clk;

    // Reference model: expected outputs derived from event timestamps.
    int m_e, m_tfall, m_tlk, m_retry;
    bit m_lphase, m_d1, m_d2;

    function automatic void model_reset();
        m_e = 0; m_tfall = PRC; m_tlk = 0; m_retry = 0;
        m_lphase = 1'b0; m_d1 = 1'b0; m_d2 = 1'b0;
    endfunction

    function automatic void model_restart();
        m_lphase = 1'b0;
        m_tfall  = m_e + PRC;
        if (m_retry < 255) m_retry++;
    endfunction

    function automatic void model_edge(input bit raw);
        bit ls;
        m_e++;
        ls   = m_d2;
        m_d2 = m_d1;
        m_d1 = raw;
        if (!m_lphase) begin
            if (m_e > m_tfall) begin
                if (ls) begin
                    m_lphase = 1'b1;
                    m_tlk    = m_e;
                end else if (m_e - m_tfall == TO) begin
                    model_restart();
                end
            end
        end else if (!ls) begin
            model_restart();
        end
    endfunction

    function automatic logic [12:0] model_out();
        int first, rel;
        if (!m_lphase)
            return {(m_e < m_tfall) ? 1'b1 : 1'b0, 3'b000, 1'b0, 8'(m_retry)};
        first = m_tlk + LS - 1;
        rel   = (m_e < first) ? 0 : (m_e - first) / SD + 1;
        if (rel > NS) rel = NS;
        return {1'b0, 3'((1 << rel) - 1), (rel == NS) ? 1'b1 : 1'b0, 8'(m_retry)};
    endfunction

    function automatic logic [12:0] dut_out();
        return {pll_rst, stage_rst_n, ready, retry_count};
    endfunction

    function automatic logic [12:0] pack(input bit pr, input bit [2:0] st, input bit rd, input int rt);
        return {pr, st, rd, 8'(rt)};
    endfunction

    task automatic check(input string name, input logic [12:0] exp);
        logic [12:0] got;
        got = dut_out();
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got pll_rst=%b stage=%b ready=%b retry=%0d, expected pll_rst=%b stage=%b ready=%b retry=%0d",
                     name, got[12], got[11:9], got[8], got[7:0], exp[12], exp[11:9], exp[8], exp[7:0]);
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic step(input bit lk);
        pll_locked = lk;
        @(posedge clk);
        model_edge(lk);
        #1;
    endtask

    typedef struct {
        bit          lock;
        int          n;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit lk, input int n, input logic [12:0] exp);
        vec_t v;
        v.lock = lk; v.n = n; v.exp = exp;
        return v;
    endfunction

    initial begin
        // Clean bring-up with E = edge 10, loss in RUN, and relock.
        vecs.push_back(mk(0, 3, pack(1, 3'b000, 0, 0)));   // edge 3
        vecs.push_back(mk(0, 1, pack(0, 3'b000, 0, 0)));   // edge 4
        vecs.push_back(mk(0, 5, pack(0, 3'b000, 0, 0)));   // edge 9
        vecs.push_back(mk(1, 1, pack(0, 3'b000, 0, 0)));   // E
        vecs.push_back(mk(1, 8, pack(0, 3'b000, 0, 0)));   // E+8
        vecs.push_back(mk(1, 1, pack(0, 3'b001, 0, 0)));   // E+9
        vecs.push_back(mk(1, 2, pack(0, 3'b001, 0, 0)));   // E+11
        vecs.push_back(mk(1, 1, pack(0, 3'b011, 0, 0)));   // E+12
        vecs.push_back(mk(1, 2, pack(0, 3'b011, 0, 0)));   // E+14
        vecs.push_back(mk(1, 1, pack(0, 3'b111, 1, 0)));   // E+15
        vecs.push_back(mk(1, 5, pack(0, 3'b111, 1, 0)));   // E+20
        vecs.push_back(mk(0, 1, pack(0, 3'b111, 1, 0)));   // F
        vecs.push_back(mk(0, 1, pack(0, 3'b111, 1, 0)));   // F+1
        vecs.push_back(mk(0, 1, pack(1, 3'b000, 0, 1)));   // F+2
        vecs.push_back(mk(0, 3, pack(1, 3'b000, 0, 1)));   // F+5
        vecs.push_back(mk(0, 1, pack(0, 3'b000, 0, 1)));   // F+6
        vecs.push_back(mk(1, 1, pack(0, 3'b000, 0, 1)));   // E'
        vecs.push_back(mk(1, 9, pack(0, 3'b001, 0, 1)));   // E'+9
        vecs.push_back(mk(1, 6, pack(0, 3'b111, 1, 1)));   // E'+15

        // Reset state, sampled while reset_n is low.
        reset_n = 1'b0;
        #12;
        check("reset_state", pack(1, 3'b000, 0, 0));

        do_reset();
        foreach (vecs[i]) begin
            repeat (vecs[i].n) step(vecs[i].lock);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Lock glitch during STABLE: lock at edge 10, low for edges 15..17.
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            step((e >= 10 && e <= 14) || e >= 18);
            if (e == 16) check("glitch_e16", pack(0, 3'b000, 0, 0));
            if (e == 17) check("glitch_e17", pack(1, 3'b000, 0, 1));
            if (e == 21) check("glitch_e21", pack(0, 3'b000, 0, 1));
            if (e == 28) check("glitch_e28", pack(0, 3'b000, 0, 1));
            if (e == 35) check("glitch_e35", pack(0, 3'b111, 1, 1));
            check("glitch_model", model_out());
        end

        // Asynchronous reset with two stages released.
        do_reset();
        for (int e = 1; e <= 22; e++) step(e >= 10);
        check("async_pre", pack(0, 3'b011, 0, 0));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", pack(1, 3'b000, 0, 0));

        // No lock: repeated timeouts, then saturation.
        do_reset();
        for (int e = 1; e <= 300 * 54; e++) begin
            step(1'b0);
            if (e == 53)       check("nolock_e53",  pack(0, 3'b000, 0, 0));
            if (e == 54)       check("nolock_e54",  pack(1, 3'b000, 0, 1));
            if (e == 58)       check("nolock_e58",  pack(0, 3'b000, 0, 1));
            if (e == 108)      check("nolock_e108", pack(1, 3'b000, 0, 2));
            if (e == 162)      check("nolock_e162", pack(1, 3'b000, 0, 3));
            if (e == 254 * 54) check("sat_254",     pack(1, 3'b000, 0, 254));
            if (e == 255 * 54) check("sat_255",     pack(1, 3'b000, 0, 255));
            if (e == 300 * 54) check("sat_300",     pack(1, 3'b000, 0, 255));
        end

        // Random lock runs against the model.
        do_reset();
        begin
            bit lvl;
            int left;
            lvl  = 1'b0;
            left = 0;
            for (int e = 0; e < 3000; e++) begin
                if (left == 0) begin
                    lvl  = ~lvl;
                    left = $urandom_range(1, 80);
                end
                left--;
                step(lvl);
                check("random", model_out());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
